demod_seq_ctrl: RTL and testbench

//  Sequencer for the ASK demodulation datapath. Enables the demodulator, waits out FIR settling,

---
 rtl/demod_seq_if.sv | 27 ++
 rtl/demod_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_demod_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/demod_seq_if.sv
// Handshake/data bundle between system control, the ASK demodulator and demod_seq_ctrl.
// The master side drives requests and demodulator results; the slave side is the sequencer.
interface demod_seq_if;
    logic       start;
    logic       stop;
    logic       rate_valid;
    logic [3:0] rate_kbps;
    logic       bit_in;
    logic       bit_in_valid;
    logic       demod_en;
    logic [3:0] rate_sel;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       locked;
    logic       err_timeout;
    logic [2:0] state_out;

    modport master (
        output start, stop, rate_valid, rate_kbps, bit_in, bit_in_valid,
        input  demod_en, rate_sel, byte_out, byte_valid, locked, err_timeout, state_out
    );

    modport slave (
        input  start, stop, rate_valid, rate_kbps, bit_in, bit_in_valid,
        output demod_en, rate_sel, byte_out, byte_valid, locked, err_timeout, state_out
    );
endinterface

// File: rtl/demod_seq_ctrl.sv
// ASK demodulator sequencer: settle, rate acquisition, byte tracking, timeout handling.
//   state  | meaning
//   IDLE   | demodulator off, waiting for start
//   SETTLE | demodulator on, FIR settling, rate readings ignored
//   ACQ    | confirming a stable legal rate; timeout -> ERR
//   TRACK  | locked; packing bits MSB-first into bytes
//   ERR    | acquisition timed out; start retries, stop returns to IDLE
module demod_seq_ctrl #(
    parameter int SETTLE_CYC  = 2048,
    parameter int CONFIRM_CYC = 64,
    parameter int ACQ_TIMEOUT = 8192000,
    parameter int GAP_TIMEOUT = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    demod_seq_if.slave        bus
);
    localparam int TMAX_A = (SETTLE_CYC > ACQ_TIMEOUT) ? SETTLE_CYC : ACQ_TIMEOUT;
    localparam int TMAX   = (TMAX_A > GAP_TIMEOUT) ? TMAX_A : GAP_TIMEOUT;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int CW     = $clog2(CONFIRM_CYC + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ACQ    = 3'd2,
        TRACK  = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer, timer_nxt;
    logic [CW-1:0] conf_cnt, conf_nxt;
    logic [3:0]    prev_rate;
    logic [7:0]    shift_reg, shift_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    byte_out_r, byte_out_nxt;
    logic          byte_valid_r, byte_valid_nxt;
    logic [3:0]    rate_sel_r, rate_sel_nxt;
    logic          demod_en_r, locked_r, err_r;
    logic          rate_legal, acq_lock, rate_chg, gap_to, take_bit;

    function automatic logic legal_rate(input logic [3:0] r);
        return (r == 4'd6) || (r == 4'd8) || (r == 4'd10);
    endfunction

    assign rate_legal = bus.rate_valid && legal_rate(bus.rate_kbps);
    assign rate_chg   = rate_legal && (bus.rate_kbps != rate_sel_r);
    assign gap_to     = !bus.bit_in_valid && (timer == '0);
    assign acq_lock   = (state == ACQ) && (conf_nxt == CW'(CONFIRM_CYC));

    // Confirm count only runs in ACQ; a run restarts at 1 on any new legal value.
    always_comb begin
        conf_nxt = '0;
        if (state == ACQ && rate_legal) begin
            if (conf_cnt != '0 && bus.rate_kbps == prev_rate)
                conf_nxt = conf_cnt + CW'(1);
            else
                conf_nxt = CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            conf_cnt     <= '0;
            prev_rate    <= '0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            byte_out_r   <= '0;
            byte_valid_r <= 1'b0;
            rate_sel_r   <= '0;
            demod_en_r   <= 1'b0;
            locked_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state        <= next_state;
            timer        <= timer_nxt;
            conf_cnt     <= (next_state == ACQ) ? conf_nxt : '0;
            prev_rate    <= bus.rate_kbps;
            shift_reg    <= shift_nxt;
            bit_cnt      <= bit_cnt_nxt;
            byte_out_r   <= byte_out_nxt;
            byte_valid_r <= byte_valid_nxt;
            rate_sel_r   <= rate_sel_nxt;
            demod_en_r   <= (next_state == SETTLE) || (next_state == ACQ) || (next_state == TRACK);
            locked_r     <= (next_state == TRACK);
            err_r        <= (next_state == ERR);
        end
    end

    // stop outranks every other event
    always_comb begin
        next_state = state;
        if (bus.stop) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) next_state = SETTLE;
                SETTLE:  if (timer == '0) next_state = ACQ;
                ACQ: begin
                    if (acq_lock)          next_state = TRACK;
                    else if (timer == '0)  next_state = ERR;
                end
                TRACK:   if (rate_chg || gap_to) next_state = ACQ;
                ERR:     if (bus.start) next_state = SETTLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Single down-counter serves settle, ACQ timeout and TRACK gap; reloaded on state entry.
    always_comb begin
        timer_nxt      = timer;
        rate_sel_nxt   = '0;
        shift_nxt      = '0;
        bit_cnt_nxt    = '0;
        byte_valid_nxt = 1'b0;
        byte_out_nxt   = byte_out_r;
        take_bit       = (state == TRACK) && (next_state == TRACK) && bus.bit_in_valid;

        if (next_state != state) begin
            case (next_state)
                SETTLE:  timer_nxt = TW'(SETTLE_CYC - 1);
                ACQ:     timer_nxt = TW'(ACQ_TIMEOUT - 1);
                TRACK:   timer_nxt = TW'(GAP_TIMEOUT - 1);
                default: timer_nxt = '0;
            endcase
        end else if (take_bit) begin
            timer_nxt = TW'(GAP_TIMEOUT - 1);
        end else if (timer != '0) begin
            timer_nxt = timer - TW'(1);
        end

        if (next_state == TRACK)
            rate_sel_nxt = (state == ACQ) ? bus.rate_kbps : rate_sel_r;

        if (state == TRACK && next_state == TRACK) begin
            shift_nxt   = shift_reg;
            bit_cnt_nxt = bit_cnt;
            if (take_bit) begin
                shift_nxt   = {shift_reg[6:0], bus.bit_in};
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid_nxt = 1'b1;
                    byte_out_nxt   = {shift_reg[6:0], bus.bit_in};
                end
            end
        end
    end

    assign bus.demod_en    = demod_en_r;
    assign bus.rate_sel    = rate_sel_r;
    assign bus.byte_out    = byte_out_r;
    assign bus.byte_valid  = byte_valid_r;
    assign bus.locked      = locked_r;
    assign bus.err_timeout = err_r;
    assign bus.state_out   = state;
endmodule

// File: tb/tb_demod_seq_ctrl.sv
// Directed bench for demod_seq_ctrl with shortened timers; bytes are checked by a queue-based monitor.
module tb_demod_seq_ctrl;
    localparam int S = 32;
    localparam int C = 16;
    localparam int A = 300;
    localparam int G = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] exp_q[$];

    demod_seq_if bus ();

    demod_seq_ctrl #(.SETTLE_CYC(S), .CONFIRM_CYC(C), .ACQ_TIMEOUT(A), .GAP_TIMEOUT(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Byte monitor: every byte_valid must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.byte_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL byte_unexpected: got %02h expected no byte", bus.byte_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.byte_out !== e) begin
                    fails++;
                    $display("FAIL byte_value: got %02h expected %02h", bus.byte_out, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in = b; bus.bit_in_valid = 1'b1; tick();
        bus.bit_in_valid = 1'b0; tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!bus.locked && n < 2000) begin tick(); n++; end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, int'(bus.state_out), 0);
        chk({tag, "_demod_en"}, int'(bus.demod_en), 0);
        chk({tag, "_rate_sel"}, int'(bus.rate_sel), 0);
        chk({tag, "_byte_out"}, int'(bus.byte_out), 0);
        chk({tag, "_byte_valid"}, int'(bus.byte_valid), 0);
        chk({tag, "_locked"}, int'(bus.locked), 0);
        chk({tag, "_err"}, int'(bus.err_timeout), 0);
    endtask

    initial begin
        int  n;
        bit  saw_lock;
        logic [7:0] b2;
        bus.start = 0; bus.stop = 0; bus.rate_valid = 0; bus.rate_kbps = 0;
        bus.bit_in = 0; bus.bit_in_valid = 0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Lock at 8 kbps from a constant reading
        bus.rate_valid = 1; bus.rate_kbps = 4'd8;
        pulse_start();
        chk("start_demod_en", int'(bus.demod_en), 1);
        chk("start_state", int'(bus.state_out), 1);
        wait_lock(n);
        chk_rng("lock_latency", n, S + C - 1, S + C + 1);
        chk("lock_state", int'(bus.state_out), 3);
        chk("lock_rate_sel", int'(bus.rate_sel), 8);

        exp_q.push_back(8'hB2);
        send_byte(8'hB2);
        b2 = 8'h7F;
        for (int i = 0; i < 7; i++) send_bit(b2[i]);
        pulse_stop();
        chk("stop_state", int'(bus.state_out), 0);
        chk("stop_locked", int'(bus.locked), 0);
        chk("stop_rate_sel", int'(bus.rate_sel), 0);
        chk("stop_demod_en", int'(bus.demod_en), 0);

        // Toggling rate never confirms -> acquisition timeout
        pulse_start();
        n = 0; saw_lock = 0;
        while (bus.state_out != 3'd4 && n < 2000) begin
            bus.rate_kbps = ((n / 8) % 2 != 0) ? 4'd10 : 4'd6;
            tick(); n++;
            if (bus.locked) saw_lock = 1;
        end
        chk("toggle_no_lock", int'(saw_lock), 0);
        chk_rng("acq_timeout_latency", n, S + A - 1, S + A + 1);
        chk("err_state", int'(bus.state_out), 4);
        chk("err_flag", int'(bus.err_timeout), 1);
        chk("err_demod_en", int'(bus.demod_en), 0);
        chk("err_rate_sel", int'(bus.rate_sel), 0);
        bus.rate_kbps = 4'd6;
        pulse_start();
        chk("err_restart_state", int'(bus.state_out), 1);
        chk("err_restart_flag", int'(bus.err_timeout), 0);

        // Lock at 6, rate change coincident with the 8th bit drops the byte
        wait_lock(n);
        chk("lock6_rate_sel", int'(bus.rate_sel), 6);
        b2 = 8'hFF;
        for (int i = 0; i < 7; i++) send_bit(b2[i]);
        bus.rate_kbps = 4'd10; bus.bit_in = 1; bus.bit_in_valid = 1; tick();
        bus.bit_in_valid = 0;
        chk("ratechg_state", int'(bus.state_out), 2);
        chk("ratechg_rate_sel", int'(bus.rate_sel), 0);
        chk("ratechg_locked", int'(bus.locked), 0);
        wait_lock(n);
        chk_rng("relock10_latency", n, C - 1, C + 1);
        chk("relock10_rate_sel", int'(bus.rate_sel), 10);
        exp_q.push_back(8'h5C);
        send_byte(8'h5C);

        // Gap timeout; illegal rates are ignored in TRACK and never lock in ACQ
        send_bit(1); send_bit(0); send_bit(1);
        bus.rate_kbps = 4'd7;
        n = 1;
        while (bus.state_out == 3'd3 && n < G + 20) begin tick(); n++; end
        chk_rng("gap_latency", n, G - 1, G + 1);
        chk("gap_state", int'(bus.state_out), 2);
        saw_lock = 0;
        for (int i = 0; i < 80; i++) begin
            bus.rate_kbps = (i < 40) ? 4'd7 : 4'd12;
            tick();
            if (bus.locked) saw_lock = 1;
        end
        chk("illegal_no_lock", int'(saw_lock), 0);
        chk("illegal_state", int'(bus.state_out), 2);

        bus.rate_kbps = 4'd8;
        wait_lock(n);
        chk("lock8_rate_sel", int'(bus.rate_sel), 8);
        bus.rate_valid = 0;
        repeat (20) tick();
        chk("novalid_state", int'(bus.state_out), 3);
        chk("novalid_rate_sel", int'(bus.rate_sel), 8);
        bus.rate_valid = 1;
        send_bit(1); send_bit(1); send_bit(0);

        // Async reset mid-TRACK
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        bus.start = 1; bus.stop = 1; tick();
        bus.start = 0; bus.stop = 0;
        chk("start_stop_state", int'(bus.state_out), 0);
        chk("start_stop_demod_en", int'(bus.demod_en), 0);
        repeat (3) tick();
        chk("bytes_outstanding", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
